mc_cunit: RTL and testbench
===========================

MC_CUNIT -- requirements
Module: mc_cunit

Interface
REQ-001 Parameter IN_WIDTH, default 32, instruction width; only bits [30], [14:12] and [6:2] are decoded.
REQ-002 Parameter OUT_WIDTH, default 15, control-word width; minimum 15; bits above 14 SHALL be driven 0.
REQ-003 Parameter MEM_TIMEOUT, default 16, maximum MEM-state cycles without mem_ack.
REQ-004 Ports: clk (in, 1, clock), rst (in, 1, reset), instr_valid (in, 1, fetch data valid), Instr (in, IN_WIDTH, instruction), instr_ready (out, 1, fetch accept).
REQ-005 Ports: Breq (in, 1, operands equal), BrLt (in, 1, rs1 < rs2), mem_req (out, 1, data-memory request), mem_ack (in, 1, data-memory done).
REQ-006 Ports: Data_out (out, OUT_WIDTH, control word), ir_we (out, 1, IR load pulse), pc_we (out, 1, PC update pulse), state_o (out, 3, current state), mem_err (out, 1, timeout pulse), illegal (out, 1, illegal-instruction pulse).
REQ-007 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-008 Control-word fields SHALL be [14] pcsel, [13:11] immsel, [10] regwen, [9] brun, [8] bsel, [7] asel, [6:3] alusel, [2] memrw, [1:0] wbsel.
REQ-009 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; state_o reflects the current state.
REQ-010 FETCH: instr_ready=1; on instr_valid=1, latch Instr into IR, pulse ir_we for that cycle, go to DECODE; instr_valid is ignored in any other state.
REQ-011 DECODE: one cycle; decode IR into a registered control word, go to EXEC.
REQ-012 EXEC: Data_out = registered word with regwen and memrw forced 0; load/store -> MEM; branch -> FETCH; ALU/LUI/AUIPC/JAL/JALR -> WB.
REQ-013 Branch: Breq/BrLt sampled in EXEC; BEQ taken if Breq; BNE (funct 1) if !Breq; BLT/BLTU if BrLt; BGE/BGEU if !BrLt; pcsel=taken; pc_we=1 in EXEC.
REQ-014 MEM: mem_req=1 and memrw passed through; on mem_ack, load -> WB, store -> FETCH with pc_we=1.
REQ-015 MEM timeout: cycle counter cleared on entry; after MEM_TIMEOUT cycles without mem_ack, pulse mem_err one cycle, drop mem_req, go to FETCH without pc_we; mem_ack in the expiry cycle wins over timeout.
REQ-016 WB: Data_out = full registered word (regwen live); pc_we=1; go to FETCH.
REQ-017 Latencies from instr_valid acceptance: ALU 4 cycles, branch 3, store 4+waits, load 5+waits.
REQ-018 Data_out SHALL be 0 in FETCH and DECODE.

Reset
REQ-019 While rst=1: state FETCH, IR 0, Data_out 0, instr_ready 0, mem_req/ir_we/pc_we/mem_err/illegal 0, counter 0.
REQ-020 Reset asserted mid-operation (including MEM) SHALL abandon the instruction; mem_req deasserts at the next clk edge.
REQ-021 First cycle after rst falls: FETCH with instr_ready=1.

Configuration
REQ-022 Macro MC_CUNIT_ILLEGAL_TRAP_EN defined: unknown opcode or unsupported funct in DECODE -> illegal=1 for one cycle in EXEC, Data_out 0, return to FETCH without pc_we.
REQ-023 Macro undefined: illegal instructions execute as NOP (Data_out 0, pc_we=1 in EXEC, -> FETCH); illegal tied 0.

Structure
REQ-024 Package cunit_pkg SHALL hold opcode constants (0,4,5,8,12,13,24,25,27), state enum, control-field bit positions and ALU select codes.
REQ-025 Combinational IR-to-control-word decoding SHALL live in sub-module cunit_dec; mc_cunit holds the FSM, IR, counter and gating.

Verification
REQ-026 ADD 0x002081B3 -> ir_we at accept, EXEC Data_out 0x0001, WB Data_out 0x0401 with pc_we=1, back to FETCH after 4 cycles.
REQ-027 BEQ 0x00208463 with Breq=1 -> EXEC Data_out 0x5180, pc_we=1; with Breq=0 -> 0x1180; no WB state entered.
REQ-028 LW 0x0000A183, mem_ack after 3 MEM cycles -> mem_req high 3 cycles, then WB with regwen=1, wbsel=00.
REQ-029 LW, MEM_TIMEOUT=8, mem_ack never -> mem_err single pulse after 8 MEM cycles, FETCH, pc_we never asserted.
REQ-030 rst=1 during MEM -> next cycle mem_req=0, Data_out=0; opcode 0x7F with macro -> illegal pulse; without macro -> pc_we pulse, illegal=0.

Source files
------------

// File: rtl/cunit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// control-word layout and ALU select codes.
package cunit_pkg;

   localparam logic [4:0] OPC_LOAD   = 5'd0;
   localparam logic [4:0] OPC_OPIMM  = 5'd4;
   localparam logic [4:0] OPC_AUIPC  = 5'd5;
   localparam logic [4:0] OPC_STORE  = 5'd8;
   localparam logic [4:0] OPC_OP     = 5'd12;
   localparam logic [4:0] OPC_LUI    = 5'd13;
   localparam logic [4:0] OPC_BRANCH = 5'd24;
   localparam logic [4:0] OPC_JALR   = 5'd25;
   localparam logic [4:0] OPC_JAL    = 5'd27;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      K_ALU     = 3'd0,
      K_LOAD    = 3'd1,
      K_STORE   = 3'd2,
      K_BRANCH  = 3'd3,
      K_ILLEGAL = 3'd4
   } kind_e;

   localparam int CW_W      = 15;
   localparam int CW_PCSEL  = 14;
   localparam int CW_IMM_LO = 11;
   localparam int CW_REGWEN = 10;
   localparam int CW_BRUN   = 9;
   localparam int CW_BSEL   = 8;
   localparam int CW_ASEL   = 7;
   localparam int CW_ALU_LO = 3;
   localparam int CW_MEMRW  = 2;
   localparam int CW_WB_LO  = 0;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // ALU codes are {instr[30], funct3} for register ops so decode is a direct map.
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLL  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SUB  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd13;
   localparam logic [3:0] ALU_BSEL = 4'd15;

   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   function automatic logic [CW_W-1:0] pack_cw(
      input logic       pcsel,
      input logic [2:0] imm,
      input logic       regwen,
      input logic       brun,
      input logic       bsel,
      input logic       asel,
      input logic [3:0] alu,
      input logic       memrw,
      input logic [1:0] wb
   );
      pack_cw = {pcsel, imm, regwen, brun, bsel, asel, alu, memrw, wb};
   endfunction

endpackage

// File: rtl/cunit_dec.sv
// Combinational decode of the instruction fields into a control word and an
// instruction class; unknown opcodes or unsupported funct values give class illegal.
module cunit_dec
   import cunit_pkg::*;
(
   input  logic [4:0]      op_i,
   input  logic [2:0]      funct3_i,
   input  logic            bit30_i,
   output logic [CW_W-1:0] cw_o,
   output logic [2:0]      kind_o
);

   always_comb begin
      cw_o   = '0;
      kind_o = K_ILLEGAL;
      case (op_i)
         OPC_LOAD: if (funct3_i != 3'd3 && funct3_i[2:1] != 2'b11) begin
            cw_o   = pack_cw(1'b0, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0, WB_MEM);
            kind_o = K_LOAD;
         end
         // instr[30] is an immediate bit except for the shift-right forms.
         OPC_OPIMM: if (!(funct3_i == 3'd1 && bit30_i)) begin
            cw_o   = pack_cw(1'b0, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0,
                             {bit30_i & (funct3_i == 3'd5), funct3_i}, 1'b0, WB_ALU);
            kind_o = K_ALU;
         end
         OPC_AUIPC: begin
            cw_o   = pack_cw(1'b0, IMM_U, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, WB_ALU);
            kind_o = K_ALU;
         end
         OPC_STORE: if (!funct3_i[2] && funct3_i != 3'd3) begin
            cw_o   = pack_cw(1'b0, IMM_S, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b1, WB_MEM);
            kind_o = K_STORE;
         end
         OPC_OP: if (!bit30_i || funct3_i == 3'd0 || funct3_i == 3'd5) begin
            cw_o   = pack_cw(1'b0, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0,
                             {bit30_i, funct3_i}, 1'b0, WB_ALU);
            kind_o = K_ALU;
         end
         OPC_LUI: begin
            cw_o   = pack_cw(1'b0, IMM_U, 1'b1, 1'b0, 1'b1, 1'b0, ALU_BSEL, 1'b0, WB_ALU);
            kind_o = K_ALU;
         end
         OPC_BRANCH: if (funct3_i[2:1] != 2'b01) begin
            cw_o   = pack_cw(1'b0, IMM_B, 1'b0, funct3_i[1], 1'b1, 1'b1, ALU_ADD, 1'b0, WB_MEM);
            kind_o = K_BRANCH;
         end
         OPC_JALR: if (funct3_i == 3'd0) begin
            cw_o   = pack_cw(1'b1, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0, WB_PC4);
            kind_o = K_ALU;
         end
         OPC_JAL: begin
            cw_o   = pack_cw(1'b1, IMM_J, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, WB_PC4);
            kind_o = K_ALU;
         end
         default: begin
            cw_o   = '0;
            kind_o = K_ILLEGAL;
         end
      endcase
   end

endmodule

// File: rtl/mc_cunit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with IR,
// MEM timeout counter and output gating. Optional macro: MC_CUNIT_ILLEGAL_TRAP_EN.
module mc_cunit
   import cunit_pkg::*;
#(
   parameter int IN_WIDTH    = 32,
   parameter int OUT_WIDTH   = 15,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   input  logic [IN_WIDTH-1:0]  Instr,
   output logic                 instr_ready,
   input  logic                 Breq,
   input  logic                 BrLt,
   output logic                 mem_req,
   input  logic                 mem_ack,
   output logic [OUT_WIDTH-1:0] Data_out,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic [2:0]           state_o,
   output logic                 mem_err,
   output logic                 illegal
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e                state_q, state_d;
   logic [IN_WIDTH-1:0]   ir_q, ir_d;
   logic [CW_W-1:0]       cw_q, cw_d;
   kind_e                 kind_q, kind_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [CW_W-1:0]       dec_cw;
   logic [2:0]            dec_kind;
   logic [CW_W-1:0]       cw_out;
   logic                  taken;
   logic                  mem_expired;
   logic                  unused_ir;

   cunit_dec u_dec (
      .op_i     (ir_q[6:2]),
      .funct3_i (ir_q[14:12]),
      .bit30_i  (ir_q[30]),
      .cw_o     (dec_cw),
      .kind_o   (dec_kind)
   );

   assign unused_ir   = ^ir_q;
   assign state_o     = state_q;
   assign mem_expired = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      case (ir_q[14:12])
         3'd0:       taken = Breq;
         3'd1:       taken = !Breq;
         3'd4, 3'd6: taken = BrLt;
         default:    taken = !BrLt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         cw_q    <= '0;
         kind_q  <= K_ALU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cw_q    <= cw_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cw_d    = cw_q;
      kind_d  = kind_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FETCH: if (instr_valid) begin
            ir_d    = Instr;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            cw_d    = dec_cw;
            kind_d  = kind_e'(dec_kind);
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            cnt_d = '0;
            case (kind_q)
               K_LOAD, K_STORE: state_d = ST_MEM;
               K_ALU:           state_d = ST_WB;
               default:         state_d = ST_FETCH;
            endcase
         end
         // An ack arriving in the expiry cycle completes the access normally.
         ST_MEM: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mem_ack)
               state_d = (kind_q == K_LOAD) ? ST_WB : ST_FETCH;
            else if (mem_expired)
               state_d = ST_FETCH;
         end
         ST_WB:   state_d = ST_FETCH;
         default: state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      mem_req     = 1'b0;
      mem_err     = 1'b0;
      illegal     = 1'b0;
      cw_out      = '0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               instr_ready = 1'b1;
               ir_we       = instr_valid;
            end
            ST_EXEC: begin
               cw_out            = cw_q;
               cw_out[CW_REGWEN] = 1'b0;
               cw_out[CW_MEMRW]  = 1'b0;
               case (kind_q)
                  K_BRANCH: begin
                     cw_out[CW_PCSEL] = taken;
                     pc_we            = 1'b1;
                  end
                  K_ILLEGAL: begin
`ifdef MC_CUNIT_ILLEGAL_TRAP_EN
                     illegal = 1'b1;
`else
                     pc_we   = 1'b1;
`endif
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req           = 1'b1;
               cw_out            = cw_q;
               cw_out[CW_REGWEN] = 1'b0;
               if (mem_ack)
                  pc_we = (kind_q == K_STORE);
               else
                  mem_err = mem_expired;
            end
            ST_WB: begin
               cw_out = cw_q;
               pc_we  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Data_out           = '0;
      Data_out[CW_W-1:0] = cw_out;
   end

endmodule

// File: tb/tb_mc_cunit.sv
// Directed bench for mc_cunit: table of single-instruction vectors plus
// hand-written memory, timeout and reset sequences.
module tb_mc_cunit;

   localparam int TO = 8;
`ifdef MC_CUNIT_ILLEGAL_TRAP_EN
   localparam logic TRAP = 1'b1;
`else
   localparam logic TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, instr_valid, Breq, BrLt, mem_ack;
   logic [31:0] Instr;
   logic        instr_ready, mem_req, ir_we, pc_we, mem_err, illegal;
   logic [15:0] Data_out;
   logic [2:0]  state_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] instr;
      logic        breq;
      logic        brlt;
      logic [15:0] exp_exec;
      logic        has_wb;
      logic [15:0] exp_wb;
      logic        is_ill;
   } vec_t;

   vec_t vecs[17];

   mc_cunit #(.IN_WIDTH(32), .OUT_WIDTH(16), .MEM_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .Instr       (Instr),
      .instr_ready (instr_ready),
      .Breq        (Breq),
      .BrLt        (BrLt),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .Data_out    (Data_out),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .state_o     (state_o),
      .mem_err     (mem_err),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accepts ins in FETCH, walks through DECODE and returns sampled in EXEC.
   task automatic fetch(input string tag, input logic [31:0] ins, input logic bq, input logic bl);
      check({tag, " fetch state"}, 32'(state_o), 32'd0);
      Instr       = ins;
      instr_valid = 1'b1;
      #1;
      check({tag, " instr_ready"}, 32'(instr_ready), 32'd1);
      check({tag, " ir_we accept"}, 32'(ir_we), 32'd1);
      step();
      Instr = 32'hFFFF_FFFF;
      Breq  = bq;
      BrLt  = bl;
      #1;
      check({tag, " decode state"}, 32'(state_o), 32'd1);
      check({tag, " decode Data_out"}, 32'(Data_out), 32'd0);
      check({tag, " decode ir_we"}, 32'(ir_we), 32'd0);
      check({tag, " decode ready"}, 32'(instr_ready), 32'd0);
      step();
      check({tag, " exec state"}, 32'(state_o), 32'd2);
      check({tag, " exec mem_req"}, 32'(mem_req), 32'd0);
      instr_valid = 1'b0;
   endtask

   task automatic mem_run(input string tag, input logic [31:0] ins, input logic is_load,
                          input int ack_cycle, input logic [15:0] exp_exec,
                          input logic [15:0] exp_mem, input logic [15:0] exp_wb);
      int req_cycles = 0;
      fetch(tag, ins, 1'b0, 1'b0);
      check({tag, " exec Data_out"}, 32'(Data_out), 32'(exp_exec));
      check({tag, " exec pc_we"}, 32'(pc_we), 32'd0);
      step();
      for (int c = 1; c <= TO; c++) begin
         mem_ack = (c == ack_cycle);
         #1;
         check($sformatf("%s mem%0d state", tag, c), 32'(state_o), 32'd3);
         check($sformatf("%s mem%0d mem_req", tag, c), 32'(mem_req), 32'd1);
         check($sformatf("%s mem%0d Data_out", tag, c), 32'(Data_out), 32'(exp_mem));
         check($sformatf("%s mem%0d mem_err", tag, c), 32'(mem_err),
               32'((c == TO) && (c != ack_cycle)));
         check($sformatf("%s mem%0d pc_we", tag, c), 32'(pc_we),
               32'((c == ack_cycle) && !is_load));
         if (mem_req) req_cycles++;
         step();
         mem_ack = 1'b0;
         if (c == ack_cycle || c == TO) break;
      end
      check({tag, " mem_req cycles"}, 32'(req_cycles), (ack_cycle == 0) ? TO : ack_cycle);
      if (is_load && ack_cycle != 0) begin
         check({tag, " wb state"}, 32'(state_o), 32'd4);
         check({tag, " wb Data_out"}, 32'(Data_out), 32'(exp_wb));
         check({tag, " wb pc_we"}, 32'(pc_we), 32'd1);
         check({tag, " wb mem_req"}, 32'(mem_req), 32'd0);
         step();
      end
      check({tag, " end state"}, 32'(state_o), 32'd0);
      check({tag, " end mem_req"}, 32'(mem_req), 32'd0);
      check({tag, " end mem_err"}, 32'(mem_err), 32'd0);
      check({tag, " end pc_we"}, 32'(pc_we), 32'd0);
   endtask

   initial begin
      //           instr         bq  bl  exec      wb   wb_word   ill
      vecs[0]  = '{32'h002081B3, 0, 0, 16'h0001, 1, 16'h0401, 0};  // ADD
      vecs[1]  = '{32'h402081B3, 0, 0, 16'h0041, 1, 16'h0441, 0};  // SUB
      vecs[2]  = '{32'h00508193, 0, 0, 16'h0101, 1, 16'h0501, 0};  // ADDI
      vecs[3]  = '{32'h4020D193, 0, 0, 16'h0169, 1, 16'h0569, 0};  // SRAI
      vecs[4]  = '{32'h123451B7, 0, 0, 16'h1979, 1, 16'h1D79, 0};  // LUI
      vecs[5]  = '{32'h00001197, 0, 0, 16'h1981, 1, 16'h1D81, 0};  // AUIPC
      vecs[6]  = '{32'h008000EF, 0, 0, 16'h6182, 1, 16'h6582, 0};  // JAL
      vecs[7]  = '{32'h000100E7, 0, 0, 16'h4102, 1, 16'h4502, 0};  // JALR
      vecs[8]  = '{32'h00208463, 1, 0, 16'h5180, 0, 16'h0000, 0};  // BEQ taken
      vecs[9]  = '{32'h00208463, 0, 0, 16'h1180, 0, 16'h0000, 0};  // BEQ not taken
      vecs[10] = '{32'h00209463, 0, 1, 16'h5180, 0, 16'h0000, 0};  // BNE taken
      vecs[11] = '{32'h0020E463, 0, 1, 16'h5380, 0, 16'h0000, 0};  // BLTU taken
      vecs[12] = '{32'h0020D463, 1, 1, 16'h1180, 0, 16'h0000, 0};  // BGE not taken
      vecs[13] = '{32'h0020F463, 0, 0, 16'h5380, 0, 16'h0000, 0};  // BGEU taken
      vecs[14] = '{32'h0000007F, 0, 0, 16'h0000, 0, 16'h0000, 1};  // unknown opcode
      vecs[15] = '{32'h0020A463, 0, 0, 16'h0000, 0, 16'h0000, 1};  // branch funct3=2
      vecs[16] = '{32'h402091B3, 0, 0, 16'h0000, 0, 16'h0000, 1};  // OP bit30 with SLL

      rst         = 1'b1;
      instr_valid = 1'b1;
      Instr       = 32'h002081B3;
      Breq        = 1'b0;
      BrLt        = 1'b0;
      mem_ack     = 1'b0;
      step();
      step();
      check("reset state", 32'(state_o), 32'd0);
      check("reset instr_ready", 32'(instr_ready), 32'd0);
      check("reset ir_we", 32'(ir_we), 32'd0);
      check("reset Data_out", 32'(Data_out), 32'd0);
      check("reset pc_we", 32'(pc_we), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset mem_err", 32'(mem_err), 32'd0);
      check("reset illegal", 32'(illegal), 32'd0);
      instr_valid = 1'b0;
      rst         = 1'b0;
      #1;
      check("post-reset instr_ready", 32'(instr_ready), 32'd1);
      check("post-reset state", 32'(state_o), 32'd0);

      for (int i = 0; i < 17; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         fetch(tag, vecs[i].instr, vecs[i].breq, vecs[i].brlt);
         check({tag, " exec Data_out"}, 32'(Data_out), 32'(vecs[i].exp_exec));
         check({tag, " exec pc_we"}, 32'(pc_we),
               32'(vecs[i].has_wb ? 1'b0 : (vecs[i].is_ill ? !TRAP : 1'b1)));
         check({tag, " exec illegal"}, 32'(illegal), 32'(vecs[i].is_ill & TRAP));
         step();
         if (vecs[i].has_wb) begin
            check({tag, " wb state"}, 32'(state_o), 32'd4);
            check({tag, " wb Data_out"}, 32'(Data_out), 32'(vecs[i].exp_wb));
            check({tag, " wb pc_we"}, 32'(pc_we), 32'd1);
            step();
         end
         check({tag, " end state"}, 32'(state_o), 32'd0);
         check({tag, " end pc_we"}, 32'(pc_we), 32'd0);
         check({tag, " end illegal"}, 32'(illegal), 32'd0);
      end

      mem_run("lw ack3",   32'h0000A183, 1'b1, 3,  16'h0100, 16'h0100, 16'h0500);
      mem_run("sw ack1",   32'h0020A223, 1'b0, 1,  16'h0900, 16'h0904, 16'h0000);
      mem_run("lw timeout", 32'h0000A183, 1'b1, 0,  16'h0100, 16'h0100, 16'h0000);
      mem_run("lw ack@exp", 32'h0000A183, 1'b1, TO, 16'h0100, 16'h0100, 16'h0500);
      mem_run("sw timeout", 32'h0020A223, 1'b0, 0,  16'h0900, 16'h0904, 16'h0000);

      fetch("rst in mem", 32'h0000A183, 1'b0, 1'b0);
      step();
      check("rst in mem mem_req before", 32'(mem_req), 32'd1);
      rst = 1'b1;
      step();
      check("rst in mem state", 32'(state_o), 32'd0);
      check("rst in mem mem_req", 32'(mem_req), 32'd0);
      check("rst in mem Data_out", 32'(Data_out), 32'd0);
      check("rst in mem instr_ready", 32'(instr_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst in mem ready after", 32'(instr_ready), 32'd1);
      fetch("after rst", 32'h002081B3, 1'b0, 1'b0);
      check("after rst exec Data_out", 32'(Data_out), 32'h0001);
      step();
      check("after rst wb Data_out", 32'(Data_out), 32'h0401);
      step();
      check("after rst end state", 32'(state_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
